// File: rtl/detect_arbiter.sv
// Round-robin arbiter sharing one bit-serial run detector among NUM_REQ frame producers.
// The granted frame is shifted LSB-first; runs of RUN_LEN ones are counted non-overlapping.
module detect_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 16,
  parameter int RUN_LEN   = 4,
  parameter int IDW       = $clog2(NUM_REQ),
  parameter int PW        = $clog2(FRAME_LEN),
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*FRAME_LEN-1:0]   frame,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           done,
  output logic [IDW-1:0]                 done_id,
  output logic                           hit,
  output logic [CW-1:0]                  hit_count,
  output logic [PW-1:0]                  hit_pos
);

  localparam int          RW = $clog2(RUN_LEN);
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_t;

  state_t                 state;
  logic [IDW-1:0]         last_grant;
  logic [IDW-1:0]         sel;
  logic [FRAME_LEN-1:0]   shreg;
  logic [RW-1:0]          run;
  logic [PW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic                   found;
  logic [PW-1:0]          pos;

  logic                   pick_valid;
  logic [IDW-1:0]         pick;
  int unsigned            cand;

  logic [RW-1:0]          run_n;
  logic [CW-1:0]          cnt_n;
  logic                   found_n;
  logic [PW-1:0]          pos_n;

  // Search upward from the requester after last_grant, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = (32'(last_grant) + i) % NR;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = IDW'(cand);
      end
    end
  end

  always_comb begin
    run_n   = run;
    cnt_n   = cnt;
    found_n = found;
    pos_n   = pos;
    if (!shreg[0]) begin
      run_n = '0;
    end else if (run == RW'(RUN_LEN - 1)) begin
      run_n = '0;
      cnt_n = cnt + CW'(1);
      if (!found) begin
        found_n = 1'b1;
        pos_n   = idx;
      end
    end else begin
      run_n = run + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      sel        <= '0;
      shreg      <= '0;
      run        <= '0;
      idx        <= '0;
      cnt        <= '0;
      found      <= 1'b0;
      pos        <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      hit        <= 1'b0;
      hit_count  <= '0;
      hit_pos    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel   <= pick;
            grant <= NUM_REQ'(1) << pick;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          shreg      <= frame[sel*FRAME_LEN +: FRAME_LEN];
          run        <= '0;
          idx        <= '0;
          cnt        <= '0;
          found      <= 1'b0;
          pos        <= '0;
          last_grant <= sel;
          state      <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          idx   <= idx + PW'(1);
          run   <= run_n;
          cnt   <= cnt_n;
          found <= found_n;
          pos   <= pos_n;
          // Results include the final bit, so they are registered on the way into REPORT.
          if (idx == PW'(FRAME_LEN - 1)) begin
            done      <= 1'b1;
            done_id   <= sel;
            hit       <= found_n;
            hit_count <= cnt_n;
            hit_pos   <= pos_n;
            state     <= REPORT;
          end
        end
        REPORT: begin
          done  <= 1'b0;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_arbiter.sv
// Directed bench for detect_arbiter: stimulus pushes expected reports into a queue,
// a negedge monitor pops and compares whenever done pulses.
module tb_detect_arbiter;

  localparam int NREQ = 4;
  localparam int FL   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*FL-1:0] frame;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              done;
  logic [1:0]        done_id;
  logic              hit;
  logic [4:0]        hit_count;
  logic [3:0]        hit_pos;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    bit h;
    int c;
    int p;
  } exp_t;

  exp_t sb[$];

  detect_arbiter #(.NUM_REQ(NREQ), .FRAME_LEN(FL), .RUN_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .grant(grant), .busy(busy),
    .done(done), .done_id(done_id), .hit(hit), .hit_count(hit_count), .hit_pos(hit_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_id %0d expected no report", done_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id", 64'(done_id), 64'(e.id));
        chk("hit", 64'(hit), 64'(e.h));
        chk("hit_count", 64'(hit_count), 64'(e.c));
        chk("hit_pos", 64'(hit_pos), 64'(e.p));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_results"}, {52'd0, done_id, hit, hit_count, hit_pos}, 64'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after REPORT.
  task automatic do_job(input logic [NREQ-1:0] rmask, input int id, input bit eh,
                        input int ec, input int ep, input bit mid_change, input bit keep_req);
    int n;
    exp_t e;
    e.id = id; e.h = eh; e.c = ec; e.p = ep;
    sb.push_back(e);
    req = rmask;
    @(negedge clk);
    chk("grant_onehot", 64'(grant), 64'(1) << id);
    chk("busy_load", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (mid_change && n == 4) begin
        req = '0;
        frame[id*FL +: FL] = 16'hFFFF;
      end
      if (!done && n > 1) chk("grant_stable", 64'(grant), 64'(1) << id);
    end
    chk("done_latency", 64'(n), 64'd17);
    if (!keep_req) req = '0;
    @(negedge clk);
    chk("idle_grant", 64'(grant), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    req   = '0;
    frame = '0;
    apply_reset();

    frame[0*FL +: FL] = 16'h000F;
    do_job(4'b0001, 0, 1'b1, 1, 3, 1'b0, 1'b0);
    frame[1*FL +: FL] = 16'hFFFF;
    do_job(4'b0010, 1, 1'b1, 4, 3, 1'b0, 1'b0);
    frame[2*FL +: FL] = 16'h0077;
    do_job(4'b0100, 2, 1'b0, 0, 0, 1'b0, 1'b0);
    frame[3*FL +: FL] = 16'h001F;
    do_job(4'b1000, 3, 1'b1, 1, 3, 1'b0, 1'b0);

    // Frame and req change during SHIFT; the report must reflect 16'h00F0.
    frame[0*FL +: FL] = 16'h00F0;
    do_job(4'b0001, 0, 1'b1, 1, 7, 1'b1, 1'b0);

    apply_reset();
    frame[0*FL +: FL] = 16'h000F;
    frame[1*FL +: FL] = 16'hFFFF;
    frame[2*FL +: FL] = 16'h0077;
    frame[3*FL +: FL] = 16'h001F;
    do_job(4'b1111, 0, 1'b1, 1, 3, 1'b0, 1'b1);
    do_job(4'b1111, 1, 1'b1, 4, 3, 1'b0, 1'b1);
    do_job(4'b1111, 2, 1'b0, 0, 0, 1'b0, 1'b1);
    do_job(4'b1111, 3, 1'b1, 1, 3, 1'b0, 1'b1);
    do_job(4'b1111, 0, 1'b1, 1, 3, 1'b0, 1'b0);

    // Abort mid-SHIFT: outputs clear immediately and no report follows.
    req = 4'b0001;
    @(negedge clk);
    chk("abort_grant_before", 64'(grant), 64'd1);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (30) @(negedge clk);
    do_job(4'b0011, 0, 1'b1, 1, 3, 1'b0, 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_arbiter.md
Name: detect_arbiter

Overview:
- Shares one bit-serial run detector among NUM_REQ requesters. Each requester offers a parallel frame.
- A round-robin arbiter grants one requester at a time. The granted frame is shifted LSB-first through the detector, which looks for RUN_LEN consecutive ones (non-overlapping).
- Reports hit flag, hit count and first-hit position. Sits between frame producers and downstream status logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FRAME_LEN, 16, bits per frame (RUN_LEN..64).
- RUN_LEN, 4, consecutive ones needed for one detection (2..FRAME_LEN).
- IDW, $clog2(NUM_REQ), width of requester index.
- PW, $clog2(FRAME_LEN), width of bit position.
- CW, $clog2(FRAME_LEN+1), width of hit count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  request per requester; level, held until matching done.
- frame  in  NUM_REQ*FRAME_LEN  requester i frame at [i*FRAME_LEN +: FRAME_LEN].
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high in LOAD, SHIFT, REPORT.
- done  out  1  one-cycle pulse in REPORT.
- done_id  out  IDW  index of finished requester.
- hit  out  1  at least one detection in finished frame.
- hit_count  out  CW  number of detections.
- hit_pos  out  PW  bit index completing the first detection; 0 if none.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; grant=0, busy=0, done=0, done_id=0, hit=0, hit_count=0, hit_pos=0.
  - last_grant=NUM_REQ-1, so req[0] has highest priority first.
  - Shift register, run counter and bit index cleared.
- FSM states: IDLE, LOAD, SHIFT, REPORT.
- IDLE:
  - If req!=0, select the first set bit searching upward (with wrap) from last_grant+1.
  - Next cycle is LOAD with grant one-hot. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - Capture selected frame into shift register.
  - Clear run counter, bit index, count and first-hit flag.
  - Update last_grant.
- SHIFT (exactly FRAME_LEN cycles): examine bit b = shreg[0], shift right, increment index.
  - b=0: run counter to 0.
  - b=1 and run counter = RUN_LEN-1: detection. count+1, run counter to 0 (non-overlapping).
  - On the first detection, record index as hit_pos.
  - b=1 otherwise: run counter +1.
  - Leave SHIFT after the index FRAME_LEN-1 bit.
- REPORT (1 cycle):
  - done=1.
  - done_id, hit, hit_count, hit_pos updated in this same cycle and held until the next REPORT.
  - Next state IDLE; grant cleared on entering IDLE.
- Latency:
  - req seen in IDLE at cycle 0 → grant at cycle 1.
  - done at cycle FRAME_LEN+2; grant drops at cycle FRAME_LEN+3.
  - At least one IDLE cycle between jobs; per-job period FRAME_LEN+3.
- grant stays stable LOAD→REPORT.
- Frame is sampled only in LOAD; later changes are ignored.
- req deasserted mid-job: job still completes and done is reported (no abort).
- New req while busy: waits; arbitration happens only in IDLE.
- All req bits set continuously: strict rotation 0,1,2,...,NUM_REQ-1,0.
- Single requester continuously: re-granted every FRAME_LEN+3 cycles.
- Reset mid-job: outputs return to reset values at once; no done is produced for the aborted job.
- Run counter never exceeds RUN_LEN-1.
- hit_count max is FRAME_LEN/RUN_LEN and never wraps.

Test Plan:
- Reset release then req=4'b0001, frame0=16'h000F → grant=4'b0001 next cycle; done at cycle 18 with hit=1, hit_count=1, hit_pos=3, done_id=0.
- req=4'b0010, frame1=16'hFFFF → hit_count=4, hit_pos=3, done_id=1.
- frame=16'h0077 (runs of 3) → hit=0, hit_count=0, hit_pos=0. frame=16'h001F (5 ones) → hit_count=1, hit_pos=3 (non-overlap).
- req=4'b1111 held for 5 jobs → grant sequence 0001,0010,0100,1000,0001. done_id 0,1,2,3,0; one IDLE cycle between each job.
- req0 dropped during SHIFT, frame0 changed during SHIFT → done still pulses. Results match the frame captured in LOAD.
- Assert rst during SHIFT at cycle 8 → grant=0, busy=0, done=0 and outputs zero in the same cycle. No done follows. A new req after release is served normally starting with req[0] priority.
